// File: rtl/prog_loader_if.sv
// Program-word stream into the loader and byte-write port out to instruction memory.
// master drives words in; slave accepts them and emits byte writes.
interface prog_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Loads 32-bit program words into byte-wide instruction memory, pads with NOPs, then runs the CPU.
// Per word: 1 accept cycle + 4 byte-write cycles; in_ready drops while writing and once capacity is hit.
module prog_loader #(
  parameter int ADDR_W      = 10,
  parameter int MAX_WORDS   = 256,
  parameter int PAD_NOPS    = 2,
  parameter int HOLD_CYCLES = 2,
  parameter int RUN_CYCLES  = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         done,
  output logic         err
);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam int CNT_W   = $clog2(MAX_WORDS + 1);
  localparam int PAD_W   = (PAD_NOPS > 0) ? $clog2(PAD_NOPS + 1) : 1;
  localparam int CYC_MAX = (HOLD_CYCLES > RUN_CYCLES) ? HOLD_CYCLES :
                           ((RUN_CYCLES > 0) ? RUN_CYCLES : 1);
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_PAD,
    ST_HOLD,
    ST_RUN,
    ST_DONE
  } state_t;

  // Zero-length phases are skipped rather than spending a cycle in them.
  localparam state_t AFTER_HOLD = (RUN_CYCLES > 0) ? ST_RUN : ST_DONE;
  localparam state_t AFTER_PAD  = (HOLD_CYCLES > 0) ? ST_HOLD : AFTER_HOLD;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [1:0]         byte_k_q, byte_k_d;
  logic [31:0]        word_q, word_d;
  logic               last_q, last_d;
  logic [PAD_W-1:0]   pad_cnt_q, pad_cnt_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               err_q, err_d;

  logic               at_cap;
  logic               writing;
  logic [31:0]        src_word;

  // Capacity reserves room for the trailing NOPs so padding can never overflow.
  assign at_cap   = (word_cnt_q == CNT_W'(MAX_WORDS - PAD_NOPS));
  assign writing  = (state_q == ST_WRITE) || (state_q == ST_PAD);
  assign src_word = (state_q == ST_PAD) ? NOP_WORD : word_q;

  assign bus.in_ready  = (state_q == ST_LOAD) && !at_cap;
  assign bus.mem_we    = writing;
  assign bus.mem_addr  = writing ? ADDR_W'({word_cnt_q, byte_k_q}) : '0;
  assign bus.mem_wdata = writing ? 8'(src_word >> {byte_k_q, 3'b000}) : 8'h00;
  assign cpu_reset     = (state_q != ST_RUN);
  assign done          = (state_q == ST_DONE);
  assign err           = err_q;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    byte_k_d   = byte_k_q;
    word_d     = word_q;
    last_d     = last_q;
    pad_cnt_d  = pad_cnt_q;
    cyc_d      = cyc_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_LOAD;
          word_cnt_d = '0;
          byte_k_d   = '0;
          pad_cnt_d  = '0;
          cyc_d      = '0;
          err_d      = 1'b0;
        end
      end

      ST_LOAD: begin
        if (bus.in_valid) begin
          if (at_cap) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            word_d   = bus.in_data;
            last_d   = bus.in_last;
            byte_k_d = '0;
            state_d  = ST_WRITE;
          end
        end
      end

      ST_WRITE, ST_PAD: begin
        byte_k_d = byte_k_q + 2'd1;
        if (byte_k_q == 2'd3) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (state_q == ST_WRITE) begin
            if (!last_q) begin
              state_d = ST_LOAD;
            end else if (PAD_NOPS > 0) begin
              state_d   = ST_PAD;
              pad_cnt_d = '0;
            end else begin
              state_d = AFTER_PAD;
            end
          end else begin
            pad_cnt_d = pad_cnt_q + PAD_W'(1);
            if (pad_cnt_q == PAD_W'(PAD_NOPS - 1)) state_d = AFTER_PAD;
          end
        end
      end

      ST_HOLD: begin
        if (cyc_q == CYC_W'(HOLD_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = AFTER_HOLD;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      ST_RUN: begin
        if (cyc_q == CYC_W'(RUN_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = ST_DONE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      byte_k_q   <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      pad_cnt_q  <= '0;
      cyc_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      byte_k_q   <= byte_k_d;
      word_q     <= word_d;
      last_q     <= last_d;
      pad_cnt_q  <= pad_cnt_d;
      cyc_q      <= cyc_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10; byte-address width of the target instruction memory.
REQ-002 SHALL have parameter MAX_WORDS, default 256; maximum 32-bit words written, program plus padding, and 4*MAX_WORDS <= 2**ADDR_W.
REQ-003 SHALL have parameter PAD_NOPS, default 2; count of NOP words (0x00000013) appended after the program.
REQ-004 SHALL have parameter HOLD_CYCLES, default 2; cycles cpu_reset stays high after the last write.
REQ-005 SHALL have parameter RUN_CYCLES, default 20; cycles the CPU runs with cpu_reset low.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  one-cycle request to begin a load/run session.
REQ-009 SHALL have port in_valid  input  1  program word present on in_data.
REQ-010 SHALL have port in_data  input  32  program word, little-endian instruction encoding.
REQ-011 SHALL have port in_last  input  1  qualifies in_data as the final program word.
REQ-012 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-013 SHALL have port mem_we  output  1  byte write strobe to instruction memory.
REQ-014 SHALL have port mem_addr  output  ADDR_W  byte address of the write.
REQ-015 SHALL have port mem_wdata  output  8  byte written.
REQ-016 SHALL have port cpu_reset  output  1  active-high reset driven to the CPU.
REQ-017 SHALL have port done  output  1  session finished (level).
REQ-018 SHALL have port err  output  1  capacity overflow occurred (level).

Function
REQ-019 SHALL implement states IDLE, LOAD, WRITE, PAD, HOLD, RUN, DONE.
REQ-020 IDLE: start=1 -> LOAD; word counter and byte address cleared to 0.
REQ-021 LOAD: in_ready=1 unless overflow; word accepted on in_valid&in_ready, latched with in_last, -> WRITE.
REQ-022 WRITE: exactly 4 consecutive cycles, mem_we=1, mem_addr=4*word_count+k, mem_wdata=word[8k+7:8k], k=0..3; word_count increments after k=3.
REQ-023 After WRITE: last=0 -> LOAD; last=1 -> PAD if PAD_NOPS>0 else HOLD.
REQ-024 PAD: writes PAD_NOPS words of 0x00000013 using the same 4-cycle byte sequence at consecutive addresses, then -> HOLD.
REQ-025 Per-word latency: 1 accept cycle + 4 write cycles; in_valid low in LOAD stalls indefinitely with no writes.
REQ-026 Overflow: in LOAD with in_valid=1 and word_count == MAX_WORDS-PAD_NOPS -> word not accepted (in_ready=0), err=1, -> DONE, no padding, CPU never released.
REQ-027 HOLD: cpu_reset=1 for exactly HOLD_CYCLES cycles, then -> RUN.
REQ-028 RUN: cpu_reset=0 for exactly RUN_CYCLES cycles, then -> DONE.
REQ-029 DONE: cpu_reset=1, done=1; start=1 clears done and err and -> LOAD as in REQ-020.
REQ-030 cpu_reset SHALL be 1 in every state except RUN; mem_we SHALL be 0 outside WRITE/PAD.
REQ-031 start SHALL be ignored in LOAD, WRITE, PAD, HOLD, RUN.
REQ-032 Counters SHALL be sized for their parameter maximum; no wrap-around within a session.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, cpu_reset=1, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, counters=0.
REQ-034 Reset asserted mid-WRITE, PAD or RUN SHALL abort without completing the word or the run; memory contents already written are left untouched.

Verification
REQ-035 Load 5 words (0x00500093, 0x00A00113, 0x00000013, 0x002081B3, 0x00302023, last on 5th) -> bytes 0..19 written in order (addr 0 = 0x93, addr 4 = 0x13), then 0x13,0x00,0x00,0x00 at 20..27, cpu_reset low exactly 20 cycles, done=1.
REQ-036 in_valid deasserted 3 cycles between words -> in_ready held, no mem_we, address sequence unchanged.
REQ-037 MAX_WORDS=4, PAD_NOPS=2, 3 words offered -> 2 words written, 3rd refused, err=1, done=1, cpu_reset never low.
REQ-038 reset pulled low during RUN cycle 7 -> cpu_reset=1 and IDLE asynchronously; subsequent start reloads from addr 0.
REQ-039 PAD_NOPS=0, HOLD_CYCLES=0, single word with last -> RUN entered the cycle after byte 3 write.
REQ-040 start pulsed during LOAD and RUN -> ignored; start in DONE -> done and err cleared, new session.
